// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the parametrised UART receiver.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK_WAIT
   } rx_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result = result + 1;
      if (result < 1) result = 1;
      return result;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the RX pin plus a 3-sample majority voter.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_RX_Serial,
   input  logic i_Sample_En,
   output logic o_RX_Sync,
   output logic o_Bit
);

   logic [1:0] sync_ff;
   logic [1:0] samples;

   // NOTE: the synchroniser resets to the idle (high) level so releasing
   // reset never looks like a start edge to the FSM.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         sync_ff <= 2'b11;
         samples <= 2'b11;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values;
         // blocking here would collapse the two synchroniser stages into one.
         sync_ff <= {sync_ff[0], i_RX_Serial};
         if (i_Sample_En) samples <= {samples[0], sync_ff[1]};
      end
   end

   assign o_RX_Sync = sync_ff[1];

   // The third vote is the live synchronised line, so the decision cycle sees
   // its own sample without waiting an extra clock.
   assign o_Bit = (samples[1] & samples[0]) |
                  (samples[1] & sync_ff[1]) |
                  (samples[0] & sync_ff[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// majority-voted sampling, false-start rejection and break detection.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
)(
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_RX_Serial,
   output logic                 o_RX_DV,
   output logic [DATA_BITS-1:0] o_RX_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int MID   = (CLKS_PER_BIT - 1) / 2;
   localparam int CNT_W = clog2(CLKS_PER_BIT);
   localparam int IDX_W = clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   rx_state_t            state, state_nxt;
   logic [CNT_W-1:0]     clk_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] data_sr;
   logic                 parity_acc;
   logic                 frame_acc;
   logic                 all_zero;

   logic rx_sync;
   logic rx_bit;
   logic sample_en;
   logic frame_done;
   logic in_window;
   logic at_dec;
   logic last_data;
   logic last_stop;
   logic parity_exp;
   logic break_now;

   uart_rx_sampler u_sampler (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_RX_Serial (i_RX_Serial),
      .i_Sample_En (sample_en),
      .o_RX_Sync   (rx_sync),
      .o_Bit       (rx_bit)
   );

   assign in_window  = (clk_cnt >= CNT_LO) && (clk_cnt <= CNT_DEC);
   assign at_dec     = (clk_cnt == CNT_DEC);
   assign last_data  = (bit_idx == IDX_W'(DATA_BITS - 1));
   assign last_stop  = (bit_idx == IDX_W'(STOP_BITS - 1));
   assign parity_exp = (PARITY == PARITY_ODD) ? ~^data_sr : ^data_sr;
   // all_zero already folds in the first stop bit once a second one is being decided.
   assign break_now  = (bit_idx == '0) ? (all_zero & ~rx_bit) : all_zero;
   assign o_Busy     = (state != S_IDLE);

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      sample_en  = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!rx_sync) state_nxt = S_START;
         end
         S_START: begin
            sample_en = in_window;
            if (at_dec) state_nxt = rx_bit ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            sample_en = in_window;
            if (at_dec && last_data)
               state_nxt = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            sample_en = in_window;
            if (at_dec) state_nxt = S_STOP;
         end
         S_STOP: begin
            sample_en = in_window;
            if (at_dec && last_stop) begin
               frame_done = 1'b1;
               state_nxt  = break_now ? S_BREAK_WAIT : S_IDLE;
            end
         end
         S_BREAK_WAIT: begin
            if (rx_sync && (clk_cnt == CNT_LAST)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         clk_cnt      <= '0;
         bit_idx      <= '0;
         data_sr      <= '0;
         parity_acc   <= 1'b0;
         frame_acc    <= 1'b0;
         all_zero     <= 1'b1;
         o_RX_DV      <= 1'b0;
         o_RX_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Break      <= 1'b0;
      end else begin
         o_RX_DV <= 1'b0;
         case (state)
            S_IDLE: begin
               clk_cnt    <= '0;
               bit_idx    <= '0;
               parity_acc <= 1'b0;
               frame_acc  <= 1'b0;
               all_zero   <= 1'b1;
            end
            S_BREAK_WAIT: begin
               // Any low sample restarts the full-bit high qualification.
               clk_cnt <= (!rx_sync || clk_cnt == CNT_LAST) ? '0 : clk_cnt + CNT_ONE;
            end
            default: begin
               // Free-running modulo counter keeps every decision at MID+1 of its bit.
               clk_cnt <= (clk_cnt == CNT_LAST) ? '0 : clk_cnt + CNT_ONE;
               if (at_dec) begin
                  case (state)
                     S_DATA: begin
                        data_sr  <= {rx_bit, data_sr[DATA_BITS-1:1]};
                        all_zero <= all_zero & ~rx_bit;
                        bit_idx  <= last_data ? '0 : bit_idx + IDX_ONE;
                     end
                     S_PARITY: begin
                        parity_acc <= (rx_bit != parity_exp);
                        all_zero   <= all_zero & ~rx_bit;
                     end
                     S_STOP: begin
                        frame_acc <= frame_acc | ~rx_bit;
                        if (bit_idx == '0) all_zero <= all_zero & ~rx_bit;
                        bit_idx <= bit_idx + IDX_ONE;
                     end
                     default: ;
                  endcase
               end
               if (frame_done) begin
                  o_RX_DV      <= 1'b1;
                  o_RX_Byte    <= break_now ? '0 : data_sr;
                  o_Parity_Err <= parity_acc;
                  o_Frame_Err  <= frame_acc | ~rx_bit;
                  o_Break      <= break_now;
                  clk_cnt      <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four instances cover default 8N1, even
// parity, two stop bits and 5-bit data, each on its own serial line.
module tb_uart_rx_param;

   localparam int T       = 40;
   localparam int CPB_DEF = 217;
   localparam int MID_DEF = (CPB_DEF - 1) / 2;
   localparam int CPB_F   = 16;

   logic       r_Clock = 1'b0;
   logic       r_Reset;
   logic [3:0] r_RX_Serial;

   always #(T/2) r_Clock = ~r_Clock;

   logic       dv0, pe0, fe0, bk0, busy0;
   logic [7:0] byte0;
   logic       dv1, pe1, fe1, bk1, busy1;
   logic [7:0] byte1;
   logic       dv2, pe2, fe2, bk2, busy2;
   logic [7:0] byte2;
   logic       dv3, pe3, fe3, bk3, busy3;
   logic [4:0] byte3;

   uart_rx_param #(.CLKS_PER_BIT(CPB_DEF)) u_def (
      .i_Clock(r_Clock), .i_Reset(r_Reset), .i_RX_Serial(r_RX_Serial[0]),
      .o_RX_DV(dv0), .o_RX_Byte(byte0), .o_Parity_Err(pe0),
      .o_Frame_Err(fe0), .o_Break(bk0), .o_Busy(busy0));

   uart_rx_param #(.CLKS_PER_BIT(CPB_F), .PARITY(2)) u_par (
      .i_Clock(r_Clock), .i_Reset(r_Reset), .i_RX_Serial(r_RX_Serial[1]),
      .o_RX_DV(dv1), .o_RX_Byte(byte1), .o_Parity_Err(pe1),
      .o_Frame_Err(fe1), .o_Break(bk1), .o_Busy(busy1));

   uart_rx_param #(.CLKS_PER_BIT(CPB_F), .STOP_BITS(2)) u_stop2 (
      .i_Clock(r_Clock), .i_Reset(r_Reset), .i_RX_Serial(r_RX_Serial[2]),
      .o_RX_DV(dv2), .o_RX_Byte(byte2), .o_Parity_Err(pe2),
      .o_Frame_Err(fe2), .o_Break(bk2), .o_Busy(busy2));

   uart_rx_param #(.CLKS_PER_BIT(CPB_F), .DATA_BITS(5)) u_d5 (
      .i_Clock(r_Clock), .i_Reset(r_Reset), .i_RX_Serial(r_RX_Serial[3]),
      .o_RX_DV(dv3), .o_RX_Byte(byte3), .o_Parity_Err(pe3),
      .o_Frame_Err(fe3), .o_Break(bk3), .o_Busy(busy3));

   int  checks = 0;
   int  errors = 0;
   int  dv_cnt [4] = '{0, 0, 0, 0};
   time t_dv0  = 0;
   time t_stop = 0;

   always @(negedge r_Clock) begin
      if (dv0) begin dv_cnt[0]++; t_dv0 = $time; end
      if (dv1) dv_cnt[1]++;
      if (dv2) dv_cnt[2]++;
      if (dv3) dv_cnt[3]++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] build_frame(input logic [8:0] data, input int dbits,
                                               input int par_bit, input logic stop1,
                                               input logic stop2, input int nstop,
                                               output int nbits);
      logic [31:0] f;
      int n;
      f = '1;
      n = 0;
      f[n] = 1'b0; n++;
      for (int i = 0; i < dbits; i++) begin f[n] = data[i]; n++; end
      if (par_bit >= 0) begin f[n] = par_bit[0]; n++; end
      f[n] = stop1; n++;
      if (nstop == 2) begin f[n] = stop2; n++; end
      nbits = n;
      return f;
   endfunction

   // Drives bits LSB first from a negedge; spike_bit gets a one-clock low at
   // the pin position whose synchronised copy is the middle vote.
   task automatic send_bits(input int lane, input logic [31:0] bits, input int nbits,
                            input int cpb, input int spike_bit);
      for (int b = 0; b < nbits; b++) begin
         if (lane == 0 && b == nbits - 1) t_stop = $time;
         for (int j = 0; j < cpb; j++) begin
            if (b == spike_bit && j == (cpb - 1) / 2 + 1) r_RX_Serial[lane] = 1'b0;
            else                                          r_RX_Serial[lane] = bits[b];
            @(negedge r_Clock);
         end
      end
      r_RX_Serial[lane] = 1'b1;
   endtask

   task automatic expect_frames(input string tag, input int lane, input int base,
                                input int want, input int budget);
      for (int i = 0; i < budget && dv_cnt[lane] < base + want; i++) @(negedge r_Clock);
      check(tag, dv_cnt[lane] - base, want);
   endtask

   initial begin
      #(T * 60000);
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] f;
      int n;
      int base;

      r_Reset     = 1'b1;
      r_RX_Serial = '1;
      repeat (3) @(negedge r_Clock);
      check("rst_dv",    dv0, 0);
      check("rst_byte",  byte0, 0);
      check("rst_flags", {pe0, fe0, bk0}, 0);
      check("rst_busy",  busy0, 0);
      r_Reset = 1'b0;
      repeat (5) @(negedge r_Clock);

      // Even parity: 0xA5 has four ones, so the correct parity bit is 0.
      base = dv_cnt[1];
      f = build_frame(9'h0A5, 8, 0, 1'b1, 1'b1, 1, n);
      send_bits(1, f, n, CPB_F, -1);
      expect_frames("par_ok_dv", 1, base, 1, 2 * CPB_F);
      check("par_ok_byte", byte1, 8'hA5);
      check("par_ok_err",  pe1, 0);

      base = dv_cnt[1];
      f = build_frame(9'h0A5, 8, 1, 1'b1, 1'b1, 1, n);
      send_bits(1, f, n, CPB_F, -1);
      expect_frames("par_bad_dv", 1, base, 1, 2 * CPB_F);
      check("par_bad_byte", byte1, 8'hA5);
      check("par_bad_err",  pe1, 1);

      // Two stop bits, second one low.
      base = dv_cnt[2];
      f = build_frame(9'h055, 8, -1, 1'b1, 1'b0, 2, n);
      send_bits(2, f, n, CPB_F, -1);
      expect_frames("stop2_dv", 2, base, 1, 2 * CPB_F);
      repeat (2 * CPB_F) @(negedge r_Clock);
      check("stop2_dv_once", dv_cnt[2] - base, 1);
      check("stop2_byte",    byte2, 8'h55);
      check("stop2_frame",   fe2, 1);
      check("stop2_break",   bk2, 0);

      // Five data bits.
      base = dv_cnt[3];
      f = build_frame(9'h01F, 5, -1, 1'b1, 1'b1, 1, n);
      send_bits(3, f, n, CPB_F, -1);
      expect_frames("d5_1f_dv", 3, base, 1, 2 * CPB_F);
      check("d5_1f_byte", byte3, 5'h1F);
      base = dv_cnt[3];
      f = build_frame(9'h00A, 5, -1, 1'b1, 1'b1, 1, n);
      send_bits(3, f, n, CPB_F, -1);
      expect_frames("d5_0a_dv", 3, base, 1, 2 * CPB_F);
      check("d5_0a_byte",  byte3, 5'h0A);
      check("d5_0a_flags", {pe3, fe3, bk3}, 0);

      // Default 8N1, 0x37. DV edge lands MID+4 clocks after the first edge
      // that sees the stop bit; that edge is half a clock after the drive and
      // DV is sampled half a clock after its edge.
      base = dv_cnt[0];
      f = build_frame(9'h037, 8, -1, 1'b1, 1'b1, 1, n);
      send_bits(0, f, n, CPB_DEF, -1);
      expect_frames("b37_dv", 0, base, 1, 2 * CPB_DEF);
      check("b37_byte",    byte0, 8'h37);
      check("b37_flags",   {pe0, fe0, bk0}, 0);
      check("b37_latency", 32'((t_dv0 - t_stop) / T) - 1, MID_DEF + 4);
      check("b37_busy",    busy0, 0);

      // Break: line low for 20 bit times.
      base = dv_cnt[0];
      r_RX_Serial[0] = 1'b0;
      repeat (20 * CPB_DEF) @(negedge r_Clock);
      check("brk_dv",    dv_cnt[0] - base, 1);
      check("brk_byte",  byte0, 8'h00);
      check("brk_flag",  bk0, 1);
      check("brk_frame", fe0, 1);
      check("brk_busy",  busy0, 1);
      r_RX_Serial[0] = 1'b1;
      repeat (CPB_DEF / 2) @(negedge r_Clock);
      check("brk_wait_busy", busy0, 1);
      repeat (CPB_DEF) @(negedge r_Clock);
      check("brk_idle",    busy0, 0);
      check("brk_dv_once", dv_cnt[0] - base, 1);

      base = dv_cnt[0];
      f = build_frame(9'h03C, 8, -1, 1'b1, 1'b1, 1, n);
      send_bits(0, f, n, CPB_DEF, -1);
      expect_frames("b3c_dv", 0, base, 1, 2 * CPB_DEF);
      check("b3c_byte",  byte0, 8'h3C);
      check("b3c_flags", {pe0, fe0, bk0}, 0);

      // Two-clock glitch on an idle line.
      base = dv_cnt[0];
      r_RX_Serial[0] = 1'b0;
      repeat (2) @(negedge r_Clock);
      r_RX_Serial[0] = 1'b1;
      repeat (2) @(negedge r_Clock);
      check("glitch_start", busy0, 1);
      repeat (CPB_DEF) @(negedge r_Clock);
      check("glitch_idle", busy0, 0);
      check("glitch_dv",   dv_cnt[0] - base, 0);

      // One-clock spike in data bit 3 (frame bit 4) of 0xFF.
      base = dv_cnt[0];
      f = build_frame(9'h0FF, 8, -1, 1'b1, 1'b1, 1, n);
      send_bits(0, f, n, CPB_DEF, 4);
      expect_frames("spike_dv", 0, base, 1, 2 * CPB_DEF);
      check("spike_byte", byte0, 8'hFF);

      // Reset during data bit 4 of 0x5A (bit 4 is 1, line left high).
      base = dv_cnt[0];
      f = build_frame(9'h05A, 8, -1, 1'b1, 1'b1, 1, n);
      send_bits(0, f, 5, CPB_DEF, -1);
      repeat (CPB_DEF / 2) @(negedge r_Clock);
      r_Reset = 1'b1;
      #1;
      check("mrst_byte",  byte0, 0);
      check("mrst_busy",  busy0, 0);
      check("mrst_flags", {dv0, pe0, fe0, bk0}, 0);
      repeat (3) @(negedge r_Clock);
      r_Reset = 1'b0;
      expect_frames("mrst_no_dv", 0, base, 0, 2 * CPB_DEF);

      base = dv_cnt[0];
      f = build_frame(9'h081, 8, -1, 1'b1, 1'b1, 1, n);
      send_bits(0, f, n, CPB_DEF, -1);
      expect_frames("b81_dv", 0, base, 1, 2 * CPB_DEF);
      check("b81_byte",  byte0, 8'h81);
      check("b81_flags", {pe0, fe0, bk0}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
